// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic row: FSM state encoding and default operand/accumulator widths.
package systolic_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ACC_W  = 64;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        COMPUTE = 3'd2,
        FLUSH   = 3'd3,
        DRAIN   = 3'd4,
        DONE    = 3'd5
    } state_e;

endpackage

// File: rtl/systolic_pe.sv
// One processing element: forwards A with its valid bit and accumulates sext(A)*sext(B).
// Define SYSTOLIC_ROW_SATURATE_EN for clamping accumulation with a sticky overflow flag; otherwise wraps.
module systolic_pe import systolic_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              clear_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] a_o,
    output logic [ACC_W-1:0]  acc_o,
    output logic              ovf_o
);

    logic                       valid_q;
    logic [DATA_W-1:0]          a_q;
    logic [ACC_W-1:0]           acc_q, acc_d;
    logic signed [2*DATA_W-1:0] a_ext_s, b_ext_s, prod_s;

    assign a_ext_s = (2*DATA_W)'($signed(a_i));
    assign b_ext_s = (2*DATA_W)'($signed(b_i));
    assign prod_s  = a_ext_s * b_ext_s;

`ifdef SYSTOLIC_ROW_SATURATE_EN
    logic signed [ACC_W:0] sum_s;
    logic                  ovf_q, ovf_d;

    // One guard bit above the accumulator exposes signed overflow.
    assign sum_s = (ACC_W+1)'($signed(acc_q)) + (ACC_W+1)'(prod_s);

    // Next accumulator: clear, saturating accumulate on a valid beat, or hold.
    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (clear_i) begin
            acc_d = {ACC_W{1'b0}};
            ovf_d = 1'b0;
        end else if (valid_i && (sum_s[ACC_W] != sum_s[ACC_W-1])) begin
            acc_d = sum_s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
            ovf_d = 1'b1;
        end else if (valid_i) begin
            acc_d = sum_s[ACC_W-1:0];
        end else begin
            acc_d = acc_q;
        end
    end

    // Sticky overflow flag.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_o = ovf_q;
`else
    logic [ACC_W-1:0] sum_s;

    assign sum_s = acc_q + ACC_W'(prod_s);

    // Next accumulator: clear, modular accumulate on a valid beat, or hold.
    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = {ACC_W{1'b0}};
        end else if (valid_i) begin
            acc_d = sum_s;
        end else begin
            acc_d = acc_q;
        end
    end

    assign ovf_o = 1'b0;
`endif

    // A/valid pipeline stage and accumulator.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            valid_q <= 1'b0;
            a_q     <= {DATA_W{1'b0}};
            acc_q   <= {ACC_W{1'b0}};
        end else begin
            valid_q <= clear_i ? 1'b0 : valid_i;
            a_q     <= a_i;
            acc_q   <= acc_d;
        end
    end

    assign valid_o = valid_q;
    assign a_o     = a_q;
    assign acc_o   = acc_q;

endmodule

// File: rtl/systolic_row.sv
// Row of NUM_PE systolic MAC elements with job FSM, B skew lines and in-order result drain.
// Optional SYSTOLIC_ROW_SATURATE_EN selects saturating accumulators with per-PE overflow flags.
module systolic_row import systolic_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int NUM_PE = 5,
    parameter int KW     = 16
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic                      start,
    input  logic [KW-1:0]             k_len,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         a_in,
    input  logic [NUM_PE*DATA_W-1:0]  b_in,
    output logic [DATA_W-1:0]         a_out,
    output logic                      a_out_valid,
    output logic [ACC_W-1:0]          res_data,
    output logic [$clog2(NUM_PE)-1:0] res_idx,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic                      busy,
    output logic                      done,
    output logic [NUM_PE-1:0]         ovf
);

    localparam int               IDX_W    = $clog2(NUM_PE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PE - 1);

    state_e            state_q, state_d;
    logic [KW-1:0]     klen_q, klen_d, cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              accept_s, last_beat_s, clear_s;
    logic [DATA_W-1:0] a_chain_s [NUM_PE+1];
    logic              v_chain_s [NUM_PE+1];
    logic [ACC_W-1:0]  acc_s [NUM_PE];

    assign accept_s    = in_valid & (state_q == COMPUTE);
    assign last_beat_s = ((cnt_q + KW'(1)) == klen_q);
    // A zero-length job skips CLEAR, so its accumulators are zeroed on the start edge.
    assign clear_s     = (state_q == CLEAR) |
                         ((state_q == IDLE) & start & (k_len == {KW{1'b0}}));

    // FSM state register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; idx_q doubles as the FLUSH cycle counter and the DRAIN index.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? ((k_len == {KW{1'b0}}) ? DRAIN : CLEAR) : IDLE;
            CLEAR:   state_d = COMPUTE;
            COMPUTE: state_d = (accept_s && last_beat_s) ? FLUSH : COMPUTE;
            FLUSH:   state_d = (idx_q == LAST_IDX) ? DRAIN : FLUSH;
            DRAIN:   state_d = (res_ready && (idx_q == LAST_IDX)) ? DONE : DRAIN;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs, all decoded from registered state.
    always_comb begin
        in_ready    = (state_q == COMPUTE);
        busy        = (state_q != IDLE);
        done        = (state_q == DONE);
        res_valid   = (state_q == DRAIN);
        a_out_valid = v_chain_s[NUM_PE] & ((state_q == COMPUTE) | (state_q == FLUSH));
        res_idx     = {IDX_W{1'b0}};
        res_data    = {ACC_W{1'b0}};
        a_out       = {DATA_W{1'b0}};
        if (res_valid) begin
            res_idx  = idx_q;
            res_data = acc_s[idx_q];
        end else begin
            res_idx  = {IDX_W{1'b0}};
        end
        if (a_out_valid) begin
            a_out = a_chain_s[NUM_PE];
        end else begin
            a_out = {DATA_W{1'b0}};
        end
    end

    // Beat, flush and drain counter next-state.
    always_comb begin
        klen_d = klen_q;
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    klen_d = k_len;
                    cnt_d  = {KW{1'b0}};
                    idx_d  = {IDX_W{1'b0}};
                end else begin
                    klen_d = klen_q;
                end
            end
            COMPUTE: cnt_d = accept_s ? (cnt_q + KW'(1)) : cnt_q;
            FLUSH:   idx_d = (idx_q == LAST_IDX) ? {IDX_W{1'b0}} : (idx_q + IDX_W'(1));
            DRAIN: begin
                if (res_ready) begin
                    idx_d = (idx_q == LAST_IDX) ? {IDX_W{1'b0}} : (idx_q + IDX_W'(1));
                end else begin
                    idx_d = idx_q;
                end
            end
            default: idx_d = idx_q;
        endcase
    end

    // Counter registers.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            klen_q <= {KW{1'b0}};
            cnt_q  <= {KW{1'b0}};
            idx_q  <= {IDX_W{1'b0}};
        end else begin
            klen_q <= klen_d;
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
        end
    end

    assign a_chain_s[0] = a_in;
    assign v_chain_s[0] = accept_s;

    for (genvar g = 0; g < NUM_PE; g++) begin : g_pe
        logic [DATA_W-1:0] b_s;

        if (g == 0) begin : g_b0
            assign b_s = b_in[DATA_W-1:0];
        end else begin : g_skew
            logic [DATA_W-1:0] skew_q [g];

            // g-deep delay so B slice g meets the A beat that needs g cycles to get here.
            always_ff @(posedge clk or posedge clr) begin
                if (clr) begin
                    for (int k = 0; k < g; k++) skew_q[k] <= {DATA_W{1'b0}};
                end else begin
                    skew_q[0] <= b_in[g*DATA_W +: DATA_W];
                    for (int k = 1; k < g; k++) skew_q[k] <= skew_q[k-1];
                end
            end

            assign b_s = skew_q[g-1];
        end

        systolic_pe #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W)
        ) u_pe (
            .clk     (clk),
            .clr     (clr),
            .clear_i (clear_s),
            .valid_i (v_chain_s[g]),
            .a_i     (a_chain_s[g]),
            .b_i     (b_s),
            .valid_o (v_chain_s[g+1]),
            .a_o     (a_chain_s[g+1]),
            .acc_o   (acc_s[g]),
            .ovf_o   (ovf[g])
        );
    end

endmodule

// File: tb/tb_systolic_row.sv
// Scoreboard bench for systolic_row: random and directed jobs checked against a dot-product model.
module tb_systolic_row;

    localparam int DATA_W = 32;
    localparam int ACC_W  = 64;
    localparam int NUM_PE = 5;
    localparam int KW     = 16;
    localparam int IDX_W  = $clog2(NUM_PE);

    logic                     clk = 1'b0;
    logic                     clr, start, in_valid, in_ready, res_valid, res_ready;
    logic                     a_out_valid, busy, done;
    logic [KW-1:0]            k_len;
    logic [DATA_W-1:0]        a_in, a_out;
    logic [NUM_PE*DATA_W-1:0] b_in;
    logic [ACC_W-1:0]         res_data;
    logic [IDX_W-1:0]         res_idx;
    logic [NUM_PE-1:0]        ovf;

    always #5 clk = ~clk;

    systolic_row #(.DATA_W(DATA_W), .ACC_W(ACC_W), .NUM_PE(NUM_PE), .KW(KW)) dut (
        .clk(clk), .clr(clr), .start(start), .k_len(k_len), .in_valid(in_valid),
        .in_ready(in_ready), .a_in(a_in), .b_in(b_in), .a_out(a_out),
        .a_out_valid(a_out_valid), .res_data(res_data), .res_idx(res_idx),
        .res_valid(res_valid), .res_ready(res_ready), .busy(busy), .done(done), .ovf(ovf)
    );

    typedef struct {
        logic [IDX_W-1:0]  idx;
        logic [ACC_W-1:0]  data;
        logic [NUM_PE-1:0] ovf;
    } exp_t;

    exp_t              exp_q[$];
    logic [DATA_W-1:0] aout_q[$];
    int                errors = 0;
    int                checks = 0;
    int                done_exp = 0;
    int                ready_mode = 0;
    int                stall_cnt = 0;
    logic signed [DATA_W-1:0] a_arr [16];
    logic signed [DATA_W-1:0] b_arr [16][NUM_PE];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference: exact dot product, clamped after every beat in the saturating build.
    function automatic logic [ACC_W-1:0] model_dot(input int pe, input int k, output logic ov);
        logic signed [127:0] acc, mx, mn;
        mx  = (128'sd1 <<< 63) - 128'sd1;
        mn  = -(128'sd1 <<< 63);
        acc = 128'sd0;
        ov  = 1'b0;
        for (int j = 0; j < k; j++) begin
            acc = acc + a_arr[j] * b_arr[j][pe];
`ifdef SYSTOLIC_ROW_SATURATE_EN
            if (acc > mx) begin
                acc = mx;
                ov  = 1'b1;
            end else if (acc < mn) begin
                acc = mn;
                ov  = 1'b1;
            end
`endif
        end
        return acc[ACC_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] rand_operand();
        case ($urandom_range(0, 3))
            0:       return DATA_W'($urandom_range(0, 200)) - 32'd100;
            1, 2:    return $urandom;
            default: return ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        endcase
    endfunction

    task automatic fill_basic();
        for (int j = 0; j < 3; j++) begin
            a_arr[j] = DATA_W'(j + 1);
            for (int p = 0; p < NUM_PE; p++) b_arr[j][p] = DATA_W'(p);
        end
    endtask

    task automatic fill_random(input int k);
        for (int j = 0; j < k; j++) begin
            a_arr[j] = rand_operand();
            for (int p = 0; p < NUM_PE; p++) b_arr[j][p] = rand_operand();
        end
    endtask

    // vmode: 0 continuous, 1 every other cycle, 2 random. rmode: 0 ready, 1 random, 2 stall at idx 2.
    task automatic run_job(input int k, input int vmode, input int rmode,
                           input bit expect_out, input bit inject_start, input bit abort_flush);
        int                j, guard;
        logic              ov;
        logic [NUM_PE-1:0] ovm;
        exp_t              e;
        ready_mode = rmode;
        stall_cnt  = 0;
        if (expect_out) begin
            ovm = '0;
            for (int p = 0; p < NUM_PE; p++) begin
                e.idx  = IDX_W'(p);
                e.data = model_dot(p, k, ov);
                ovm[p] = ov;
                exp_q.push_back(e);
            end
            for (int p = exp_q.size() - NUM_PE; p < exp_q.size(); p++) exp_q[p].ovf = ovm;
            done_exp++;
        end
        @(posedge clk); #1;
        start = 1'b1;
        k_len = KW'(k);
        @(posedge clk); #1;
        start = 1'b0;
        k_len = KW'($urandom);
        j = 0;
        guard = 0;
        while (j < k && guard < 2000) begin
            if (vmode == 0)      in_valid = 1'b1;
            else if (vmode == 1) in_valid = (guard % 2 == 0);
            else                 in_valid = ($urandom_range(0, 3) != 0);
            a_in = in_valid ? a_arr[j] : $urandom;
            for (int p = 0; p < NUM_PE; p++)
                b_in[p*DATA_W +: DATA_W] = in_valid ? b_arr[j][p] : $urandom;
            @(negedge clk);
            if (in_valid && in_ready) begin
                if (expect_out) aout_q.push_back(a_arr[j]);
                j++;
            end
            guard++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("beats_accepted", j, k);
        if (abort_flush) begin
            @(posedge clk); #1;
            check("flush_before_clr", {busy, in_ready, res_valid}, 3'b100);
            clr = 1'b1;
            #1;
            check("clr_ctrl_zero", {busy, in_ready, res_valid, done, a_out_valid, res_idx, ovf}, 128'd0);
            check("clr_data_zero", {a_out, res_data}, 128'd0);
            repeat (2) @(posedge clk);
            #1;
            clr = 1'b0;
            return;
        end
        if (inject_start) begin
            guard = 0;
            while (!res_valid && guard < 200) begin
                @(posedge clk); #1;
                guard++;
            end
            @(posedge clk); #1;
            start = 1'b1;
            k_len = KW'(3);
            @(posedge clk); #1;
            start = 1'b0;
        end
        guard = 0;
        while (busy && guard < 500) begin
            @(posedge clk); #1;
            guard++;
        end
        check("job_idle", busy, 1'b0);
        check("job_done_seen", done_exp, 0);
        check("job_results_left", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        check("stay_idle", busy, 1'b0);
    endtask

    // Ready driver.
    initial begin
        res_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                1: res_ready = ($urandom_range(0, 2) != 0);
                2: begin
                    if (res_valid && res_idx == IDX_W'(2) && stall_cnt < 4) begin
                        res_ready = 1'b0;
                        stall_cnt++;
                    end else begin
                        res_ready = 1'b1;
                    end
                end
                default: res_ready = 1'b1;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every result transfer, A beat and done pulse.
    initial begin
        logic              hold_v, prev_done;
        logic [ACC_W-1:0]  hold_data;
        logic [IDX_W-1:0]  hold_idx;
        exp_t              e;
        hold_v    = 1'b0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (clr) begin
                hold_v    = 1'b0;
                prev_done = 1'b0;
            end else begin
                if (!busy || res_valid) check("in_ready_low", in_ready, 1'b0);
                if (res_valid) begin
                    if (hold_v) begin
                        check("res_hold_data", res_data, hold_data);
                        check("res_hold_idx", res_idx, hold_idx);
                    end
                    if (res_ready) begin
                        hold_v = 1'b0;
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_result: idx=%0d data=0x%0h, none expected",
                                     res_idx, res_data);
                        end else begin
                            e = exp_q.pop_front();
                            check("res_idx", res_idx, e.idx);
                            check("res_data", res_data, e.data);
                            check("ovf", ovf, e.ovf);
                        end
                    end else begin
                        hold_v    = 1'b1;
                        hold_data = res_data;
                        hold_idx  = res_idx;
                    end
                end else begin
                    hold_v = 1'b0;
                end
                if (a_out_valid) begin
                    if (aout_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_a_out: got 0x%0h, none expected", a_out);
                    end else begin
                        check("a_out", a_out, aout_q.pop_front());
                    end
                end
                if (done) begin
                    check("done_single_pulse", prev_done, 1'b0);
                    check("done_after_results", exp_q.size(), 0);
                    if (done_exp == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: done pulse with no job pending");
                    end else begin
                        done_exp--;
                    end
                end
                prev_done = done;
            end
        end
    end

    initial begin
        clr      = 1'b1;
        start    = 1'b0;
        k_len    = '0;
        in_valid = 1'b0;
        a_in     = '0;
        b_in     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", {busy, in_ready, res_valid, done, a_out_valid, res_idx, ovf}, 128'd0);
        check("reset_data", {a_out, res_data}, 128'd0);
        clr = 1'b0;

        fill_basic();
        run_job(3, 0, 0, 1'b1, 1'b0, 1'b0);
        run_job(3, 1, 0, 1'b1, 1'b0, 1'b0);
        run_job(3, 0, 2, 1'b1, 1'b0, 1'b0);
        check("stall_cycles", stall_cnt, 4);

        for (int j = 0; j < 3; j++) begin
            a_arr[j] = 32'h7FFF_FFFF;
            for (int p = 0; p < NUM_PE; p++) b_arr[j][p] = 32'h7FFF_FFFF;
        end
        run_job(3, 0, 0, 1'b1, 1'b0, 1'b0);

        fill_basic();
        run_job(3, 0, 0, 1'b0, 1'b0, 1'b1);
        run_job(3, 2, 0, 1'b1, 1'b0, 1'b0);

        run_job(0, 0, 0, 1'b1, 1'b1, 1'b0);

        for (int t = 0; t < 25; t++) begin
            int k;
            k = $urandom_range(0, 10);
            fill_random(k);
            run_job(k, (t % 3 == 0) ? 1 : 2, 1, 1'b1, 1'b0, 1'b0);
        end

        repeat (5) @(posedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        check("a_out_queue_empty", aout_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/systolic_row.md
SYSTOLIC_ROW -- requirements
Module: systolic_row

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand width (signed two's complement).
REQ-002 SHALL have parameter ACC_W, default 64, accumulator width; ACC_W >= 2*DATA_W.
REQ-003 SHALL have parameter NUM_PE, default 5, PE count in the row; legal range 2..16.
REQ-004 SHALL have parameter KW, default 16, width of the dot-product length field.
REQ-005 SHALL have port clk, input, 1, single clock; all flops on rising edge.
REQ-006 SHALL have port clr, input, 1, asynchronous, active-high reset.
REQ-007 SHALL have port start, input, 1, begin a job; sampled only in IDLE.
REQ-008 SHALL have port k_len, input, KW, number of MAC beats per job; sampled with start.
REQ-009 SHALL have port in_valid, input, 1, a_in and b_in carry a beat.
REQ-010 SHALL have port in_ready, output, 1, row accepts a beat (high only in COMPUTE).
REQ-011 SHALL have port a_in, input, DATA_W, row operand broadcast systolically from PE0.
REQ-012 SHALL have port b_in, input, NUM_PE*DATA_W, column operands, PE i in slice i, presented time-aligned.
REQ-013 SHALL have port a_out, output, DATA_W, A leaving the last PE (for row chaining).
REQ-014 SHALL have port a_out_valid, output, 1, a_out carries a beat.
REQ-015 SHALL have port res_data, output, ACC_W, drained accumulator.
REQ-016 SHALL have port res_idx, output, $clog2(NUM_PE), PE index of res_data.
REQ-017 SHALL have port res_valid / res_ready, output / input, 1 each, drain handshake.
REQ-018 SHALL have port busy, output, 1, state != IDLE.
REQ-019 SHALL have port done, output, 1, one-cycle pulse after the last result transfers.
REQ-020 SHALL have port ovf, output, NUM_PE, per-PE sticky overflow flags.

Function
REQ-021 FSM SHALL have states IDLE, CLEAR, COMPUTE, FLUSH, DRAIN, DONE.
REQ-022 IDLE->CLEAR on start; k_len==0 SHALL go IDLE->DRAIN directly with all accumulators zeroed.
REQ-023 CLEAR SHALL last 1 cycle, zero all accumulators, ovf and pipeline valid bits, then go to COMPUTE.
REQ-024 COMPUTE SHALL accept a beat when in_valid && in_ready; it SHALL leave COMPUTE after beat k_len is accepted; in_valid low stalls without loss.
REQ-025 A SHALL advance one PE per cycle with a valid bit; PE i SHALL see beat j at acceptance cycle + i.
REQ-026 b_in slice i SHALL be delayed internally by i cycles (skew registers) so each PE pairs the matching A and B beats.
REQ-027 PE SHALL accumulate acc += sext(a)*sext(b) only when its valid bit is set; bubbles contribute nothing.
REQ-028 FLUSH SHALL last exactly NUM_PE cycles, so that the last beat has been added in PE NUM_PE-1 when DRAIN begins.
REQ-029 DRAIN SHALL present PE0..PE(NUM_PE-1) in order; res_valid high throughout; index advances only on res_valid && res_ready.
REQ-030 res_data/res_idx SHALL hold stable while res_valid && !res_ready.
REQ-031 After the last transfer: DRAIN->DONE (done=1 for one cycle)->IDLE.
REQ-032 start outside IDLE SHALL be ignored; no job queueing.
REQ-033 a_out/a_out_valid SHALL be valid in COMPUTE and FLUSH.

Reset
REQ-034 clr SHALL force state IDLE and set every output, accumulator, skew register and valid bit to 0 immediately, including mid-job; the aborted job produces no results and no done pulse.

Configuration
REQ-035 With SYSTOLIC_ROW_SATURATE_EN defined, accumulators SHALL clamp to the signed ACC_W max/min on overflow and set the matching ovf bit (sticky until CLEAR or clr).
REQ-036 Without SYSTOLIC_ROW_SATURATE_EN, accumulators SHALL wrap modulo 2^ACC_W and ovf SHALL be tied to 0.

Structure
REQ-037 Package systolic_pkg SHALL hold the FSM state enum and the default DATA_W/ACC_W constants.
REQ-038 Sub-module systolic_pe SHALL implement one PE (A register, valid bit, accumulator, saturation); systolic_row instantiates NUM_PE of them via generate, together with the FSM and skew logic.

Verification
REQ-039 NUM_PE=5, k_len=3, a={1,2,3}, b_i={i,i,i} continuous -> results 6i for i=0..4, res_idx 0..4, one done pulse.
REQ-040 Same job with in_valid toggling every other cycle -> identical results; in_ready low outside COMPUTE.
REQ-041 res_ready held low 4 cycles during index 2 -> res_data=12 stable, no index skipped or repeated.
REQ-042 Saturation build, DATA_W=32, ACC_W=64, a=b=0x7FFFFFFF, k_len=3 -> results 0x7FFFFFFFFFFFFFFF, ovf=5'b11111; wrap build -> wrapped sum, ovf=0.
REQ-043 clr asserted during FLUSH -> all outputs 0 next cycle, busy=0; a new job afterwards returns correct results.
REQ-044 k_len=0 -> five results of 0, then done; a start during DRAIN -> ignored.
